// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the decode helpers used on the execute-side accept path.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_t;

   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (f3)
         F3_H, F3_HU: bad = off[0];
         F3_W:        bad = (off != 2'b00);
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] m;
      case (f3)
         F3_B:    m = 4'b0001 << off;
         F3_H:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Replicate the store operand across every lane it could land in, so the
   // byte mask alone selects what the memory actually writes.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      case (f3)
         F3_B:    r = {4{d[7:0]}};
         F3_H:    r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a returned memory word.
module load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'd0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one access from execute, issues a single memory
// request, waits for read data with a timeout, and returns the aligned result.
module lsu_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic [2:0]        ex_funct3,
   input  logic [31:0]       ex_addr,
   input  logic [31:0]       ex_wdata,
   output logic              lsu_busy,
   output logic              mem_request,
   output logic              mem_we_re,
   output logic              mem_load,
   output logic [3:0]        mem_mask,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_wdata,
   input  logic              mem_valid,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic              lsu_err
);
   import lsu_pkg::*;

   localparam logic [2:0] CNT_LAST = 3'(TIMEOUT - 1);

   lsu_state_t        state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        mask_q, mask_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              store_q, store_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              wb_valid_q, wb_valid_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              err_q, err_d;

   logic [31:0]       aligned;
   logic              in_req;

   // Byte-address bits above the memory's word address are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^ex_addr[31:ADDR_W+2];

   load_align u_load_align (
      .funct3 (f3_q),
      .offset (off_q),
      .rdata  (mem_rdata),
      .data   (aligned)
   );

   always_comb begin
      state_d    = state_q;
      f3_d       = f3_q;
      off_d      = off_q;
      addr_d     = addr_q;
      mask_d     = mask_q;
      wdata_d    = wdata_q;
      store_d    = store_q;
      cnt_d      = cnt_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (ex_load && ex_store) begin
                  err_d = 1'b1;
               end else if (ex_load || ex_store) begin
                  if (!f3_legal(ex_funct3, ex_store) || misaligned(ex_funct3, ex_addr[1:0])) begin
                     err_d = 1'b1;
                  end else begin
                     f3_d    = ex_funct3;
                     off_d   = ex_addr[1:0];
                     addr_d  = ex_addr[ADDR_W+1:2];
                     mask_d  = store_mask(ex_funct3, ex_addr[1:0]);
                     wdata_d = store_data(ex_funct3, ex_wdata);
                     store_d = ex_store;
                     state_d = REQ;
                  end
               end
            end
         end
         REQ: begin
            cnt_d   = 3'd0;
            state_d = store_q ? IDLE : WAIT;
         end
         WAIT: begin
            // A response on the final allowed cycle still wins over the timeout.
            if (mem_valid) begin
               wb_data_d  = aligned;
               wb_valid_d = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         f3_q       <= 3'd0;
         off_q      <= 2'd0;
         addr_q     <= '0;
         mask_q     <= 4'd0;
         wdata_q    <= 32'd0;
         store_q    <= 1'b0;
         cnt_q      <= 3'd0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         addr_q     <= addr_d;
         mask_q     <= mask_d;
         wdata_q    <= wdata_d;
         store_q    <= store_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
      end
   end

   // Memory-side outputs are decoded purely from registered state and are
   // held at zero outside the request cycle.
   assign in_req      = (state_q == REQ);
   assign lsu_busy    = (state_q != IDLE);
   assign mem_request = in_req;
   assign mem_we_re   = in_req && store_q;
   assign mem_load    = in_req && !store_q;
   assign mem_mask    = in_req ? (store_q ? mask_q : 4'b1111) : 4'b0000;
   assign mem_address = in_req ? addr_q : '0;
   assign mem_wdata   = (in_req && store_q) ? wdata_q : 32'd0;
   assign wb_valid    = wb_valid_q;
   assign wb_data     = wb_data_q;
   assign lsu_err     = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table plus reset/timeout sequences.
module tb_lsu_ctrl;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 4;
   localparam int NV      = 18;

   logic              clk;
   logic              rst;
   logic              ex_valid;
   logic              ex_load;
   logic              ex_store;
   logic [2:0]        ex_funct3;
   logic [31:0]       ex_addr;
   logic [31:0]       ex_wdata;
   logic              lsu_busy;
   logic              mem_request;
   logic              mem_we_re;
   logic              mem_load;
   logic [3:0]        mem_mask;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_wdata;
   logic              mem_valid;
   logic [31:0]       mem_rdata;
   logic              wb_valid;
   logic [31:0]       wb_data;
   logic              lsu_err;

   lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_load     (ex_load),
      .ex_store    (ex_store),
      .ex_funct3   (ex_funct3),
      .ex_addr     (ex_addr),
      .ex_wdata    (ex_wdata),
      .lsu_busy    (lsu_busy),
      .mem_request (mem_request),
      .mem_we_re   (mem_we_re),
      .mem_load    (mem_load),
      .mem_mask    (mem_mask),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_valid   (mem_valid),
      .mem_rdata   (mem_rdata),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .lsu_err     (lsu_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  mask;
      logic [7:0]  waddr;
      logic [31:0] mwdata;
      logic [31:0] wb;
   } vec_t;

   vec_t        vecs[NV];
   logic [31:0] exp_q[$];
   logic [31:0] last_wb;
   int          checks;
   int          errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err,
                               input logic [3:0] mask, input logic [7:0] waddr,
                               input logic [31:0] mwdata, input logic [31:0] wb);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.err = err; v.mask = mask; v.waddr = waddr;
      v.mwdata = mwdata; v.wb = wb;
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(lsu_busy), 32'd0);
      chk({tag, "_req"}, 32'(mem_request), 32'd0);
      chk({tag, "_we"}, 32'(mem_we_re), 32'd0);
      chk({tag, "_load"}, 32'(mem_load), 32'd0);
      chk({tag, "_mask"}, 32'(mem_mask), 32'd0);
      chk({tag, "_addr"}, 32'(mem_address), 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
      chk({tag, "_wbd"}, wb_data, 32'd0);
      chk({tag, "_err"}, 32'(lsu_err), 32'd0);
   endtask

   task automatic drive_access(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
      ex_valid  = 1'b1;
      ex_load   = ld;
      ex_store  = st;
      ex_funct3 = f3;
      ex_addr   = addr;
      ex_wdata  = wdata;
      @(posedge clk); #1;
      ex_valid  = 1'b0;
      ex_load   = 1'b0;
      ex_store  = 1'b0;
   endtask

   // Entered #1 after an edge with the DUT idle; returns the same way.
   task automatic run_vec(input int i);
      vec_t v;
      int   k;
      logic [31:0] exp_wb;
      v = vecs[i];
      if (v.ld && !v.err) exp_q.push_back(v.wb);
      drive_access(v.ld, v.st, v.f3, v.addr, v.wdata);
      chk("c1_wbv_low", 32'(wb_valid), 32'd0);
      if (v.err) begin
         chk("err_pulse", 32'(lsu_err), 32'd1);
         chk("err_no_req", 32'(mem_request), 32'd0);
         chk("err_busy", 32'(lsu_busy), 32'd0);
         @(posedge clk); #1;
         chk("err_clear", 32'(lsu_err), 32'd0);
         chk("err_no_req2", 32'(mem_request), 32'd0);
         $display("vec %0d: reject ld=%0b st=%0b f3=%0d addr=0x%08h err=%0b", i, v.ld, v.st, v.f3, v.addr, lsu_err);
      end else begin
         chk("req", 32'(mem_request), 32'd1);
         chk("we_re", 32'(mem_we_re), 32'(v.st));
         chk("mem_load", 32'(mem_load), 32'(v.ld));
         chk("mask", 32'(mem_mask), 32'(v.mask));
         chk("address", 32'(mem_address), 32'(v.waddr));
         chk("busy_c1", 32'(lsu_busy), 32'd1);
         chk("no_err_c1", 32'(lsu_err), 32'd0);
         if (v.st) begin
            chk("store_wdata", mem_wdata, v.mwdata);
            @(posedge clk); #1;
            chk("store_busy_c2", 32'(lsu_busy), 32'd0);
            chk("store_req_c2", 32'(mem_request), 32'd0);
            chk("wb_hold", wb_data, last_wb);
            $display("vec %0d: store f3=%0d addr=0x%08h mask=%b wdata=0x%08h", i, v.f3, v.addr, v.mask, v.mwdata);
         end else begin
            @(posedge clk); #1;
            mem_valid = 1'b1;
            mem_rdata = v.rdata;
            chk("load_busy_c2", 32'(lsu_busy), 32'd1);
            chk("load_req_c2", 32'(mem_request), 32'd0);
            k = 0;
            do begin
               @(posedge clk); #1;
               mem_valid = 1'b0;
               mem_rdata = $urandom;
               k++;
            end while (!wb_valid && !lsu_err && k < 8);
            chk("wb_latency", 32'(k), 32'd1);
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("load_busy_c3", 32'(lsu_busy), 32'd0);
            chk("load_no_err", 32'(lsu_err), 32'd0);
            if (wb_valid && exp_q.size() > 0) begin
               exp_wb = exp_q.pop_front();
               chk("wb_data", wb_data, exp_wb);
               last_wb = exp_wb;
            end
            $display("vec %0d: load f3=%0d addr=0x%08h rdata=0x%08h wb=0x%08h", i, v.f3, v.addr, v.rdata, wb_data);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      checks  = 0;
      errors  = 0;
      last_wb = 32'd0;
      rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
      mem_valid = 1'b0; mem_rdata = 32'd0;

      //            ld    st    f3      addr          wdata         rdata         err  mask   waddr  mwdata        wb
      vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 8'h04, 32'h0,        32'hDEADBEEF);
      vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h00000013, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 8'h04, 32'h0,        32'hFFFFFF80);
      vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h00000013, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 8'h04, 32'h0,        32'h00000080);
      vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h00000012, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 8'h04, 32'h0,        32'hFFFF80FF);
      vecs[4]  = mk(1'b1, 1'b0, 3'b101, 32'h00000012, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 8'h04, 32'h0,        32'h000080FF);
      vecs[5]  = mk(1'b1, 1'b0, 3'b000, 32'h00000011, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 8'h04, 32'h0,        32'h0000007F);
      vecs[6]  = mk(1'b1, 1'b0, 3'b001, 32'h00000010, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 8'h04, 32'h0,        32'h00007F01);
      vecs[7]  = mk(1'b1, 1'b0, 3'b010, 32'hFFFF03FC, 32'h0,        32'h12345678, 1'b0, 4'hF, 8'hFF, 32'h0,        32'h12345678);
      vecs[8]  = mk(1'b0, 1'b1, 3'b000, 32'h00000021, 32'h000000AB, 32'h0,        1'b0, 4'h2, 8'h08, 32'hABABABAB, 32'h0);
      vecs[9]  = mk(1'b0, 1'b1, 3'b001, 32'h00000022, 32'h1234CDEF, 32'h0,        1'b0, 4'hC, 8'h08, 32'hCDEFCDEF, 32'h0);
      vecs[10] = mk(1'b0, 1'b1, 3'b010, 32'h0000003C, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF, 8'h0F, 32'hCAFEF00D, 32'h0);
      vecs[11] = mk(1'b0, 1'b1, 3'b000, 32'h00000023, 32'h55667788, 32'h0,        1'b0, 4'h8, 8'h08, 32'h88888888, 32'h0);
      vecs[12] = mk(1'b1, 1'b0, 3'b010, 32'h00000002, 32'h0,        32'h0,        1'b1, 4'h0, 8'h00, 32'h0,        32'h0);
      vecs[13] = mk(1'b1, 1'b0, 3'b011, 32'h00000010, 32'h0,        32'h0,        1'b1, 4'h0, 8'h00, 32'h0,        32'h0);
      vecs[14] = mk(1'b1, 1'b1, 3'b010, 32'h00000010, 32'h0,        32'h0,        1'b1, 4'h0, 8'h00, 32'h0,        32'h0);
      vecs[15] = mk(1'b0, 1'b1, 3'b100, 32'h00000010, 32'h0,        32'h0,        1'b1, 4'h0, 8'h00, 32'h0,        32'h0);
      vecs[16] = mk(1'b1, 1'b0, 3'b001, 32'h00000013, 32'h0,        32'h0,        1'b1, 4'h0, 8'h00, 32'h0,        32'h0);
      vecs[17] = mk(1'b0, 1'b1, 3'b001, 32'h00000021, 32'h0,        32'h0,        1'b1, 4'h0, 8'h00, 32'h0,        32'h0);

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      $display("reset: all outputs checked idle");

      for (int i = 0; i < NV; i++) run_vec(i);

      // Load with no response: timeout error after TIMEOUT WAIT cycles.
      drive_access(1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0);
      chk("to_req", 32'(mem_load), 32'd1);
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
         if (!lsu_err) chk("to_no_wbv", 32'(wb_valid), 32'd0);
      end while (!lsu_err && k < 12);
      chk("to_latency", 32'(k), 32'(TIMEOUT + 1));
      chk("to_err", 32'(lsu_err), 32'd1);
      chk("to_wbv", 32'(wb_valid), 32'd0);
      chk("to_busy", 32'(lsu_busy), 32'd0);
      chk("to_wb_hold", wb_data, last_wb);
      $display("timeout: err after %0d cycles busy=%0b", k, lsu_busy);

      // Stray memory response while idle must be ignored.
      mem_valid = 1'b1;
      mem_rdata = 32'h0BADF00D;
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); #1;
         chk("stray_wbv", 32'(wb_valid), 32'd0);
         chk("stray_err", 32'(lsu_err), 32'd0);
         chk("stray_busy", 32'(lsu_busy), 32'd0);
      end
      mem_valid = 1'b0;
      $display("stray mem_valid in IDLE: ignored");

      // Reset while waiting abandons the load.
      drive_access(1'b1, 1'b0, 3'b010, 32'h00000044, 32'h0);
      @(posedge clk); #1;
      chk("rw_busy_wait", 32'(lsu_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("rst_wait");
      rst = 1'b0;
      mem_valid = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         chk("post_rst_wbv", 32'(wb_valid), 32'd0);
         chk("post_rst_err", 32'(lsu_err), 32'd0);
         chk("post_rst_busy", 32'(lsu_busy), 32'd0);
      end
      mem_valid = 1'b0;
      last_wb = 32'd0;
      $display("reset in WAIT: transaction abandoned");

      run_vec(0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
